// File: rtl/inst_mem_pkg.sv
// Shared definitions for the instruction memory: default geometry, controller
// state encoding and the all-zero instruction word.
package inst_mem_pkg;

    localparam int INST_WIDTH_DEF = 64;
    localparam int DEPTH_DEF      = 1024;
    localparam int ADDR_WIDTH_DEF = 32;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [INST_WIDTH_DEF-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/inst_mem_array.sv
// Instruction storage: one write port and one synchronous read port. A read and
// a write to the same word in the same cycle return the previous contents.
module inst_mem_array #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [IDX_W-1:0] ridx,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // No reset: boot-loaded contents must survive a reset of the controller.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wdata;
        end
        if (re) begin
            rdata <= mem[ridx];
        end
    end

endmodule

// File: rtl/inst_mem.sv
// Instruction memory controller: BOOT/RUN sequencing, fetch decode with
// alignment/range checking, and a one-deep response register with backpressure.
module inst_mem
    import inst_mem_pkg::*;
#(
    parameter int INST_WIDTH = INST_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ce,
    input  logic                     flush,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_WIDTH-1:0]    req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [INST_WIDTH-1:0]    rsp_inst,
    output logic                     rsp_err,
    input  logic                     ld_we,
    input  logic [$clog2(DEPTH)-1:0] ld_idx,
    input  logic [INST_WIDTH-1:0]    ld_data,
    input  logic                     ld_done,
    output logic                     booted
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int BYTES  = INST_WIDTH / 8;
    localparam int B_W    = $clog2(BYTES);
    localparam int HI_LSB = IDX_W + B_W;

    localparam logic [ADDR_WIDTH-1:0] BYTE_MASK = ADDR_WIDTH'(BYTES - 1);
    localparam logic [INST_WIDTH-1:0] ZERO_INST = INST_WIDTH'(ZERO_WORD);

    state_t                state;
    logic                  err_q;
    logic [IDX_W-1:0]      fetch_idx;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  fetch_err;
    logic                  accept;
    logic [INST_WIDTH-1:0] rd_data;

    assign fetch_idx    = req_addr[HI_LSB-1:B_W];
    assign misaligned   = (req_addr & BYTE_MASK) != '0;
    assign out_of_range = (req_addr >> HI_LSB) != '0;
    assign fetch_err    = misaligned || out_of_range;

    assign req_ready = (state == ST_RUN) && ce && (!rsp_valid || rsp_ready);
    // flush vetoes a request even when req_ready is shown high that cycle.
    assign accept    = req_valid && req_ready && !flush;

    inst_mem_array #(
        .WIDTH (INST_WIDTH),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (ld_we),
        .widx  (ld_idx),
        .wdata (ld_data),
        .re    (accept && !fetch_err),
        .ridx  (fetch_idx),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_BOOT;
            booted    <= 1'b0;
            rsp_valid <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            unique case (state)
                ST_BOOT: begin
                    if (ld_done) begin
                        state  <= ST_RUN;
                        booted <= 1'b1;
                    end
                end
                ST_RUN: begin
                    state  <= ST_RUN;
                    booted <= 1'b1;
                end
                default: begin
                    state  <= ST_BOOT;
                    booted <= 1'b0;
                end
            endcase

            if (flush) begin
                rsp_valid <= 1'b0;
            end else if (accept) begin
                rsp_valid <= 1'b1;
                err_q     <= fetch_err;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    // The array read register only loads on an accepted good fetch, so the
    // presented word stays put while the response is held.
    assign rsp_err  = rsp_valid && err_q;
    assign rsp_inst = (rsp_valid && !err_q) ? rd_data : ZERO_INST;

endmodule

// File: tb/tb_inst_mem.sv
// Randomized scoreboard bench for inst_mem against an array/queue reference.
module tb_inst_mem;

    localparam int W     = 64;
    localparam int D     = 1024;
    localparam int AW    = 32;
    localparam int IW    = 10;
    localparam int LOADN = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce, flush, req_valid, req_ready, rsp_valid, rsp_ready;
    logic          rsp_err, ld_we, ld_done, booted;
    logic [AW-1:0] req_addr;
    logic [W-1:0]  rsp_inst, ld_data;
    logic [IW-1:0] ld_idx;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [W-1:0] inst;
        logic         err;
    } exp_t;

    logic [W-1:0] ref_mem [D];
    bit           ref_run = 1'b0;
    bit           ref_pending = 1'b0;
    exp_t         exp_q[$];

    bit           held = 1'b0;
    logic [W-1:0] h_inst;
    logic         h_err;

    inst_mem #(.INST_WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_inst  (rsp_inst),
        .rsp_err   (rsp_err),
        .ld_we     (ld_we),
        .ld_idx    (ld_idx),
        .ld_data   (ld_data),
        .ld_done   (ld_done),
        .booted    (booted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    // Reference fetch: byte address -> word via plain division.
    function automatic exp_t model_fetch(input logic [AW-1:0] a);
        exp_t            e;
        longint unsigned ua;
        ua = longint'(a);
        if ((ua % 8) != 0 || (ua / 8) >= D) begin
            e.err  = 1'b1;
            e.inst = '0;
        end else begin
            e.err  = 1'b0;
            e.inst = ref_mem[ua / 8];
        end
        return e;
    endfunction

    // Called at posedge+1; drives one cycle of inputs, advances the model.
    task automatic step(input logic v, input logic [AW-1:0] a, input logic rr, input logic c,
                        input logic f, input logic we, input int idx, input logic [W-1:0] d,
                        input logic done);
        bit exp_ready, acc;
        req_valid = v;
        req_addr  = a;
        rsp_ready = rr;
        ce        = c;
        flush     = f;
        ld_we     = we;
        ld_idx    = IW'(idx);
        ld_data   = d;
        ld_done   = done;
        #1;
        exp_ready = ref_run && c && (!ref_pending || rr);
        chk_bit("req_ready", req_ready, exp_ready);
        chk_bit("booted", booted, ref_run);
        acc = v && exp_ready && !f;
        if (f && ref_pending && !rr && exp_q.size() > 0) exp_q.delete(0);
        if (acc) exp_q.push_back(model_fetch(a));
        if (f)        ref_pending = 1'b0;
        else if (acc) ref_pending = 1'b1;
        else if (rr)  ref_pending = 1'b0;
        if (we) ref_mem[idx] = d;
        if (!ref_run && done) ref_run = 1'b1;
        @(posedge clk);
        #1;
        chk_bit("rsp_valid", rsp_valid, ref_pending);
    endtask

    task automatic idle(input logic rr);
        step(1'b0, '0, rr, 1'b1, 1'b0, 1'b0, 0, '0, 1'b0);
    endtask

    task automatic fetch(input logic [AW-1:0] a, input logic rr);
        step(1'b1, a, rr, 1'b1, 1'b0, 1'b0, 0, '0, 1'b0);
    endtask

    task automatic load(input int idx, input logic [W-1:0] d);
        step(1'b1, '0, 1'b1, 1'b1, 1'b0, 1'b1, idx, d, 1'b0);
    endtask

    task automatic do_reset(input int cycles);
        rst       = 1'b0;
        req_valid = 1'b0;
        ld_we     = 1'b0;
        ld_done   = 1'b0;
        flush     = 1'b0;
        #1;
        chk_bit("rst_rsp_valid", rsp_valid, 1'b0);
        chk_bit("rst_req_ready", req_ready, 1'b0);
        chk_bit("rst_booted", booted, 1'b0);
        chk_bit("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_rsp_inst", rsp_inst, '0);
        ref_run     = 1'b0;
        ref_pending = 1'b0;
        exp_q.delete();
        repeat (cycles) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Monitor: pops on each handshake, checks idle zeros and hold stability.
    initial begin
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    chk_bit("hold_valid", rsp_valid, 1'b1);
                    chk("hold_inst", rsp_inst, h_inst);
                    chk_bit("hold_err", rsp_err, h_err);
                end
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL rsp_unexpected: got inst %h, want no response", rsp_inst);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("rsp_inst", rsp_inst, e.inst);
                        chk_bit("rsp_err", rsp_err, e.err);
                    end
                end else if (!rsp_valid) begin
                    chk("idle_inst", rsp_inst, '0);
                    chk_bit("idle_err", rsp_err, 1'b0);
                end
                held   = rsp_valid && !rsp_ready && !flush;
                h_inst = rsp_inst;
                h_err  = rsp_err;
            end
        end
    end

    initial begin
        logic [W-1:0] w;
        rst       = 1'b0;
        ce        = 1'b1;
        flush     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b1;
        ld_we     = 1'b0;
        ld_idx    = '0;
        ld_data   = '0;
        ld_done   = 1'b0;
        do_reset(2);

        // Boot load, then booted rises the cycle after ld_done.
        for (int i = 0; i < LOADN; i++) begin
            case (i)
                0:       w = 64'h2080c00000000000;
                1:       w = 64'h0000001300100093;
                2:       w = 64'h00208133deadbeef;
                3:       w = 64'h0000006f12345678;
                default: w = {$urandom, $urandom};
            endcase
            load(i, w);
        end
        step(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 0, '0, 1'b1);
        idle(1'b1);

        fetch(32'h8, 1'b1);
        idle(1'b1);

        fetch(32'h0, 1'b1);
        fetch(32'h8, 1'b1);
        fetch(32'h10, 1'b1);
        idle(1'b1);

        // Backpressure: response held three cycles, requests refused.
        fetch(32'h18, 1'b1);
        repeat (3) fetch(32'h20, 1'b0);
        fetch(32'h20, 1'b1);
        idle(1'b1);

        fetch(32'h4, 1'b1);
        fetch(32'h2000, 1'b1);
        idle(1'b1);

        // Read-first on a same-cycle patch write, then the new value.
        step(1'b1, 32'h28, 1'b1, 1'b1, 1'b0, 1'b1, 5, {4{16'hAAAA}}, 1'b0);
        fetch(32'h28, 1'b1);
        idle(1'b1);

        step(1'b1, 32'h30, 1'b1, 1'b0, 1'b0, 1'b0, 0, '0, 1'b0);
        idle(1'b1);

        for (int n = 0; n < 600; n++) begin
            int unsigned   idx;
            logic [AW-1:0] a;
            idx = $urandom_range(0, LOADN - 1);
            case ($urandom % 8)
                0:       a = AW'(idx * 8 + $urandom_range(1, 7));
                1:       a = AW'(idx * 8) | (32'h1 << $urandom_range(13, 31));
                default: a = AW'(idx * 8);
            endcase
            step(1'($urandom % 4 != 0), a, 1'($urandom % 4 != 0), 1'($urandom % 8 != 0),
                 1'($urandom % 16 == 0), 1'($urandom % 8 == 0), int'($urandom_range(0, LOADN - 1)),
                 {$urandom, $urandom}, 1'($urandom % 2));
        end
        idle(1'b1);
        idle(1'b1);

        // Flush a held response, then reset twice around a partial reload.
        fetch(32'h10, 1'b0);
        idle(1'b0);
        step(1'b1, 32'h18, 1'b0, 1'b1, 1'b1, 1'b0, 0, '0, 1'b0);
        idle(1'b0);
        do_reset(1);
        fetch(32'h0, 1'b1);
        for (int i = 0; i < 4; i++) load(i, {$urandom, $urandom});
        do_reset(1);
        load(8, {$urandom, $urandom});
        load(9, {$urandom, $urandom});
        step(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 0, '0, 1'b1);
        for (int i = 0; i < 16; i++) fetch(AW'(i * 8), 1'b1);
        idle(1'b1);
        idle(1'b1);

        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d responses outstanding, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
